// File: rtl/video_in_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : video_in_pack_if
// Purpose  : Pixel-stream input, FIFO write side and status of video_in_pack.
//            Optional error counters exist when VIDEO_IN_ERR_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface video_in_pack_if #(
  parameter int PIX_W = 8,
  parameter int PACK  = 4
);
  logic                  line_valid;
  logic                  frame_valid;
  logic [PIX_W-1:0]      pixel_in;
  logic                  fifo_full;
  logic                  w_e;
  logic [PIX_W*PACK-1:0] w_data;
  logic                  frame_done;
  logic                  err_line;
  logic                  err_frame;
  logic                  ovf;
`ifdef VIDEO_IN_ERR_CNT_EN
  logic [15:0]           err_line_cnt;
  logic [15:0]           err_frame_cnt;
  logic [15:0]           ovf_cnt;
`endif

`ifdef VIDEO_IN_ERR_CNT_EN
  modport master (
    output line_valid, frame_valid, pixel_in, fifo_full,
    input  w_e, w_data, frame_done, err_line, err_frame, ovf,
    input  err_line_cnt, err_frame_cnt, ovf_cnt
  );
  modport slave (
    input  line_valid, frame_valid, pixel_in, fifo_full,
    output w_e, w_data, frame_done, err_line, err_frame, ovf,
    output err_line_cnt, err_frame_cnt, ovf_cnt
  );
`else
  modport master (
    output line_valid, frame_valid, pixel_in, fifo_full,
    input  w_e, w_data, frame_done, err_line, err_frame, ovf
  );
  modport slave (
    input  line_valid, frame_valid, pixel_in, fifo_full,
    output w_e, w_data, frame_done, err_line, err_frame, ovf
  );
`endif
endinterface
`default_nettype wire

// File: rtl/video_in_pack.sv
`default_nettype none
// ============================================================================
// Module   : video_in_pack
// Purpose  : Video capture front-end: geometry check and PACK-pixel word packing
//            into a downstream FIFO. VIDEO_IN_ERR_CNT_EN adds error counters.
// Revision : 1.0  initial release
// ============================================================================
module video_in_pack #(
  parameter int PIX_W  = 8,
  parameter int PACK   = 4,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CW     = 10
) (
  input wire             clk,
  input wire             RST,
  video_in_pack_if.slave bus
);
  localparam int c_SW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int c_DW = PIX_W * PACK;

  generate
    if (WIDTH % PACK != 0) begin : g_chk_pack
      $error("video_in_pack: WIDTH must be a multiple of PACK");
    end
    if ((2 ** CW) <= WIDTH || (2 ** CW) <= HEIGHT) begin : g_chk_cw
      $error("video_in_pack: CW too small for WIDTH/HEIGHT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_col, r_row, w_row_end;
  logic              r_col_over, r_row_over, w_row_over_end;
  logic [c_SW-1:0]   r_slot;
  logic [c_DW-1:0]   r_pack, w_pack_nxt, r_w_data;
  logic              r_lv_q, r_w_e, r_frame_done, r_err_line, r_err_frame, r_ovf;
  logic              w_accept, w_line_end, w_frame_end, w_in_range;
  logic              w_line_bad, w_frame_bad, w_last_slot, w_drop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:  if (!bus.frame_valid) w_state_nxt = S_IDLE;
      S_IDLE:  if (bus.frame_valid)  w_state_nxt = S_FRAME;
      S_FRAME: if (!bus.frame_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_comb begin
    w_accept    = (r_state != S_SYNC) && bus.frame_valid && bus.line_valid;
    w_line_end  = r_lv_q && !w_accept;
    w_frame_end = (r_state == S_FRAME) && !bus.frame_valid;
    w_in_range  = (r_col < CW'(WIDTH)) && (r_row < CW'(HEIGHT));
    w_last_slot = (r_slot == c_SW'(PACK - 1));
    w_drop      = w_accept && w_in_range && w_last_slot && bus.fifo_full;
    // Counters stop at the limit; the over flags remember that it was exceeded.
    w_row_end      = r_row;
    w_row_over_end = r_row_over;
    if (w_line_end && (r_col != '0)) begin
      if (r_row == CW'(HEIGHT)) w_row_over_end = 1'b1;
      else                      w_row_end      = r_row + CW'(1);
    end
    w_line_bad  = (r_col != CW'(WIDTH)) || r_col_over;
    w_frame_bad = (w_row_end != CW'(HEIGHT)) || w_row_over_end;
    w_pack_nxt  = r_pack;
    for (int i = 0; i < PACK; i++) begin
      if (r_slot == c_SW'(i)) w_pack_nxt[(PACK-1-i)*PIX_W +: PIX_W] = bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state      <= S_SYNC;
      r_col        <= '0;
      r_row        <= '0;
      r_col_over   <= 1'b0;
      r_row_over   <= 1'b0;
      r_slot       <= '0;
      r_pack       <= '0;
      r_lv_q       <= 1'b0;
      r_w_e        <= 1'b0;
      r_w_data     <= '0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lv_q       <= w_accept;
      r_w_e        <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
      if (w_accept) begin
        if (r_col == CW'(WIDTH)) r_col_over <= 1'b1;
        else                     r_col      <= r_col + CW'(1);
        if (w_in_range) begin
          r_pack <= w_pack_nxt;
          r_slot <= w_last_slot ? '0 : r_slot + c_SW'(1);
          if (w_last_slot) begin
            if (bus.fifo_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_w_e    <= 1'b1;
              r_w_data <= w_pack_nxt;
            end
          end
        end
      end
      if (w_line_end) begin
        r_err_line <= w_line_bad;
        r_col      <= '0;
        r_col_over <= 1'b0;
        r_slot     <= '0;
        r_row      <= w_row_end;
        r_row_over <= w_row_over_end;
      end
      if (w_frame_end) begin
        r_frame_done <= 1'b1;
        r_err_frame  <= w_frame_bad;
        r_col        <= '0;
        r_col_over   <= 1'b0;
        r_row        <= '0;
        r_row_over   <= 1'b0;
        r_slot       <= '0;
      end
    end
  end

  assign bus.w_e        = r_w_e;
  assign bus.w_data     = r_w_data;
  assign bus.frame_done = r_frame_done;
  assign bus.err_line   = r_err_line;
  assign bus.err_frame  = r_err_frame;
  assign bus.ovf        = r_ovf;

`ifdef VIDEO_IN_ERR_CNT_EN
  logic [15:0] r_err_line_cnt, r_err_frame_cnt, r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_err_line_cnt  <= '0;
      r_err_frame_cnt <= '0;
      r_ovf_cnt       <= '0;
    end else begin
      if (w_line_end && w_line_bad && (r_err_line_cnt != 16'hFFFF))
        r_err_line_cnt <= r_err_line_cnt + 16'd1;
      if (w_frame_end && w_frame_bad && (r_err_frame_cnt != 16'hFFFF))
        r_err_frame_cnt <= r_err_frame_cnt + 16'd1;
      if (w_drop && (r_ovf_cnt != 16'hFFFF))
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign bus.err_line_cnt  = r_err_line_cnt;
  assign bus.err_frame_cnt = r_err_frame_cnt;
  assign bus.ovf_cnt       = r_ovf_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_video_in_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_in_pack
// Purpose  : Scoreboard bench for video_in_pack (WIDTH=8, HEIGHT=2, PACK=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_video_in_pack;
  localparam int c_K_WORD  = 0;
  localparam int c_K_LINE  = 1;
  localparam int c_K_FRAME = 2;
  localparam int c_K_DONE  = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  video_in_pack_if #(.PIX_W(8), .PACK(4)) bus ();

  video_in_pack #(
    .PIX_W(8), .PACK(4), .WIDTH(8), .HEIGHT(2), .CW(4)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pulse becomes visible one cycle after the inputs driven now.
  task automatic push(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_evt(input int kind, input logic [31:0] data);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_pulse: kind %0d data %h at cycle %0d, nothing expected", kind, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
        n_err++;
        $display("FAIL pulse: got kind %0d data %h cycle %0d expected kind %0d data %h cycle %0d",
                 kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: got nothing expected kind %0d data %h at cycle %0d",
                 q[0].kind, q[0].data, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.w_e)        chk_evt(c_K_WORD, bus.w_data);
      if (bus.err_line)   chk_evt(c_K_LINE, 32'h0);
      if (bus.err_frame)  chk_evt(c_K_FRAME, 32'h0);
      if (bus.frame_done) chk_evt(c_K_DONE, 32'h0);
    end
  end

  task automatic start_frame(input bit gap);
    bus.frame_valid = 1'b1;
    bus.line_valid  = 1'b0;
    if (gap) step();
  endtask

  // n pixels base..base+n-1; the first nwords groups are expected, except full_word.
  task automatic drive_line(input int n, input int base, input int nwords, input int full_word);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      bus.line_valid = 1'b1;
      bus.pixel_in   = 8'(base + i);
      acc            = {acc[23:0], 8'(base + i)};
      bus.fifo_full  = (i % 4 == 3) && (i / 4 == full_word);
      if ((i % 4 == 3) && (i / 4 < nwords) && (i / 4 != full_word)) push(c_K_WORD, acc);
      step();
    end
    bus.fifo_full = 1'b0;
  endtask

  task automatic end_line(input bit exp_err);
    bus.line_valid = 1'b0;
    if (exp_err) push(c_K_LINE, 32'h0);
    step();
    step();
  endtask

  task automatic end_frame(input bit exp_err_line, input bit exp_err_frame);
    bus.frame_valid = 1'b0;
    bus.line_valid  = 1'b0;
    if (exp_err_line)  push(c_K_LINE, 32'h0);
    if (exp_err_frame) push(c_K_FRAME, 32'h0);
    push(c_K_DONE, 32'h0);
    step();
    step();
  endtask

  task automatic nominal_frame(input int base);
    start_frame(1'b1);
    drive_line(8, base, 2, -1);
    end_line(1'b0);
    drive_line(8, base + 8, 2, -1);
    end_line(1'b0);
    end_frame(1'b0, 1'b0);
  endtask

  initial begin
    RST             = 1'b1;
    bus.frame_valid = 1'b0;
    bus.line_valid  = 1'b0;
    bus.pixel_in    = '0;
    bus.fifo_full   = 1'b0;
    step();
    step();
    chk("rst_w_e", {31'b0, bus.w_e}, 32'h0);
    chk("rst_w_data", bus.w_data, 32'h0);
    chk("rst_frame_done", {31'b0, bus.frame_done}, 32'h0);
    chk("rst_err_line", {31'b0, bus.err_line}, 32'h0);
    chk("rst_err_frame", {31'b0, bus.err_frame}, 32'h0);
    chk("rst_ovf", {31'b0, bus.ovf}, 32'h0);
    RST = 1'b0;
    step();
    step();

    // 1: nominal frame, pixels 0x00..0x0F
    nominal_frame(8'h00);
    chk("s1_ovf", {31'b0, bus.ovf}, 32'h0);

    // 2: short second line
    start_frame(1'b1);
    drive_line(8, 8'h10, 2, -1);
    end_line(1'b0);
    drive_line(6, 8'h18, 1, -1);
    end_line(1'b1);
    end_frame(1'b0, 1'b0);

    // 3: long first line
    start_frame(1'b1);
    drive_line(10, 8'h20, 2, -1);
    end_line(1'b1);
    drive_line(8, 8'h30, 2, -1);
    end_line(1'b0);
    end_frame(1'b0, 1'b0);

    // 4: FIFO full on the second word of line 0
    start_frame(1'b1);
    drive_line(8, 8'h40, 2, 1);
    end_line(1'b0);
    chk("s4_ovf_set", {31'b0, bus.ovf}, 32'h1);
    drive_line(8, 8'h48, 2, -1);
    end_line(1'b0);
    end_frame(1'b0, 1'b0);

    // 5: three lines in a frame
    start_frame(1'b1);
    drive_line(8, 8'h50, 2, -1);
    end_line(1'b0);
    drive_line(8, 8'h58, 2, -1);
    end_line(1'b0);
    drive_line(8, 8'h60, 0, -1);
    end_line(1'b0);
    end_frame(1'b0, 1'b1);
    chk("s5_ovf_sticky", {31'b0, bus.ovf}, 32'h1);

    // 6: reset mid-line; rest of frame must be ignored
    start_frame(1'b1);
    drive_line(3, 8'h70, 0, -1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("s6_ovf_cleared", {31'b0, bus.ovf}, 32'h0);
    drive_line(5, 8'h73, 0, -1);
    end_line(1'b0);
    drive_line(8, 8'h78, 0, -1);
    end_line(1'b0);
    bus.frame_valid = 1'b0;
    step();
    step();
    nominal_frame(8'h80);

    // 7: frame starts with a pixel and ends with line_valid still high
    start_frame(1'b0);
    drive_line(8, 8'h90, 2, -1);
    end_line(1'b0);
    drive_line(8, 8'h98, 2, -1);
    end_frame(1'b0, 1'b0);

    chk("final_ovf", {31'b0, bus.ovf}, 32'h0);
    step();
    step();
    step();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d pulses outstanding expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/video_in_pack.md
Name: video_in_pack

Overview:
- Parametrised video capture front-end.
- Samples the pixel stream from the display/camera model (line_valid, frame_valid, pixel_in).
- Tracks column and line position and checks frame geometry.
- Packs PACK consecutive pixels into one word and writes it to the downstream FIFO, honouring FIFO back-pressure and reporting line, frame and overflow errors.

Parameters:
PIX_W, 8, bits per pixel
PACK, 4, pixels per FIFO word; WIDTH % PACK must be 0 (elaboration $error otherwise)
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
CW, 10, column/line counter width; must satisfy 2**CW > max(WIDTH, HEIGHT)

Ports:
clk  in  1  clock
RST  in  1  synchronous reset, active high
line_valid  in  1  pixel qualifier within a line
frame_valid  in  1  high for the whole frame
pixel_in  in  PIX_W  pixel data, valid when line_valid & frame_valid
fifo_full  in  1  downstream FIFO cannot accept a write this cycle
w_e  out  1  FIFO write strobe, one-cycle pulse
w_data  out  PIX_W*PACK  packed word; first pixel of the group in the MSBs
frame_done  out  1  one-cycle pulse at each frame end
err_line  out  1  one-cycle pulse: completed line length != WIDTH
err_frame  out  1  one-cycle pulse: completed frame line count != HEIGHT
ovf  out  1  sticky: a word was dropped because fifo_full was high

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous on RST.
- Reset values: w_e=0, w_data=0, frame_done=0, err_line=0, err_frame=0, ovf=0. Counters col=0, row=0. State=SYNC.
- FSM states:
  - SYNC: wait for frame_valid=0, then go to IDLE. Any frame in progress is ignored, so RST asserted mid-frame drops the rest of that frame with no error pulses.
  - IDLE: frame_valid=1 -> FRAME (col=0, row=0). If line_valid=1 in the same cycle, the pixel is accepted.
  - FRAME: accept a pixel when frame_valid & line_valid.
- Pixel accept:
  - If col < WIDTH and row < HEIGHT, the pixel goes into slot (col % PACK) of the pack register; slot 0 is the MSBs.
  - col increments saturating at WIDTH. Pixels with col >= WIDTH or row >= HEIGHT are discarded (no write).
- Word write:
  - When slot PACK-1 is filled, on the next cycle:
    - fifo_full=0 -> w_e=1, w_data=packed word.
    - fifo_full=1 -> w_e=0 and ovf set.
  - Latency: last pixel of the group sampled at cycle N -> w_e at N+1. fifo_full is sampled at cycle N.
  - w_data holds its value until the next write. Throughput is 1 pixel/cycle with no stalls; there is no upstream back-pressure.
- Line end (falling line_valid while frame_valid=1, or both falling together):
  - Next cycle: err_line=1 if col != WIDTH.
  - A partial word from a short line is discarded.
  - col<=0. row increments saturating at HEIGHT, only if the line had col>0.
- Frame end (falling frame_valid):
  - Next cycle: frame_done=1, plus err_frame=1 if the final row != HEIGHT. The final row includes a line ending in the same cycle.
  - Then state=IDLE.
  - If line_valid was still high, this also counts as a line end, and err_line and err_frame may pulse together.
- line_valid=1 while frame_valid=0 is ignored.
- ovf clears only on RST.
- col and row never wrap; they saturate as stated.

Optional Feature:
- Macro: VIDEO_IN_ERR_CNT_EN.
- Defined: adds outputs err_line_cnt[15:0], err_frame_cnt[15:0] and ovf_cnt[15:0].
  - Each counts its event (err_line pulse, err_frame pulse, dropped word).
  - Each saturates at 16'hFFFF and resets to 0 on RST.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
All scenarios use PIX_W=8, PACK=4, WIDTH=8, HEIGHT=2.
1. Nominal frame, pixels 0x00..0x0F, 2 lines of 8, gaps between lines -> 4 w_e pulses with w_data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, each 1 cycle after the 4th pixel; frame_done pulse; no errors.
2. Line 1 carries only 6 pixels -> 1 word from line 1, partial discarded, err_line at line end; err_frame=0 because row=2; 3 words total.
3. Line 0 carries 10 pixels -> pixels 9..10 dropped, 2 words, err_line pulse; line 1 normal.
4. fifo_full=1 during the 2nd word of line 0 -> that word is missing, ovf=1 and stays 1 across the next frame until RST.
5. Frame with 3 lines -> 3rd line produces no writes; err_frame and frame_done pulse together.
6. RST mid-line with frame_valid held high -> no writes until frame_valid falls and rises again; the next full frame gives 4 correct words.
